throw_sequencer: RTL
====================

THROW_SEQUENCER -- requirements
Module: throw_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 833333, clk cycles per step tick (60 Hz at 50 MHz).
REQ-002 SHALL have parameter GROUND_Y, default 445, ball Y value at or beyond which the ball has landed.
REQ-003 SHALL have parameter VEL_MAX, default 500, clamp limit for both velocity components.
REQ-004 SHALL have parameter MAX_STEPS, default 255, flight step limit used only when the timeout feature is compiled in.
REQ-005 SHALL have ports: clk  in  1  system clock, single clock domain; all logic on its rising edge.
REQ-006 SHALL have ports: rst  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports: launch  in  1  launch button, already synchronised, level.
REQ-008 SHALL have ports: vel_x_in, vel_y_in  in  10 each  requested velocities, unsigned.
REQ-009 SHALL have ports: ball_y  in  9  current ball Y from the ball datapath.
REQ-010 SHALL have ports: step  out  1  one-clk pulse that advances the ball datapath.
REQ-011 SHALL have ports: go  out  1  start request to the datapath.
REQ-012 SHALL have ports: ball_rst  out  1  active-high datapath reset.
REQ-013 SHALL have ports: vel_x, vel_y  out  10 each  latched, clamped velocities.
REQ-014 SHALL have ports: step_cnt  out  11  steps issued in the current throw.
REQ-015 SHALL have ports: throws  out  8  completed-throw count.
REQ-016 SHALL have ports: busy, landed, timeout  out  1 each  status flags.

Function
REQ-017 SHALL run a free prescaler 0..TICK_DIV-1 and raise an internal tick for one clk on the terminal count.
REQ-018 SHALL detect a launch rising edge as launch=1 with the previous-cycle launch=0.
REQ-019 SHALL implement states IDLE, ARM, FLIGHT, LANDED and ABORT.
REQ-020 In IDLE: ball_rst=1, go=0, busy=0; a launch edge SHALL move to ARM, latch min(vel_*_in, VEL_MAX), clear step_cnt, landed and timeout.
REQ-021 In ARM: ball_rst=0, go=1, busy=1; on the next tick step SHALL pulse, then the state moves to FLIGHT.
REQ-022 In FLIGHT: go=1, busy=1; on each tick with ball_y < GROUND_Y, step SHALL pulse and step_cnt SHALL increment, saturating at 2047.
REQ-023 In FLIGHT, a tick with ball_y >= GROUND_Y SHALL move to LANDED without a step pulse; throws SHALL increment once, saturating at 255.
REQ-024 In LANDED: landed=1, busy=0, go=0; positions are held; a launch edge SHALL move to IDLE.
REQ-025 In ABORT: timeout=1, busy=0, go=0; throws SHALL be unchanged; a launch edge SHALL move to IDLE.
REQ-026 step SHALL never be high outside ARM or FLIGHT and SHALL never be high for two consecutive clks.
REQ-027 Launch edges in ARM and FLIGHT SHALL be ignored.
REQ-028 vel_x and vel_y SHALL be stable from ARM entry until the next IDLE-to-ARM transition.
REQ-029 If landing and the step limit occur on the same tick, landing SHALL win.

Reset
REQ-030 Asserting rst=0 SHALL immediately force IDLE, prescaler=0, step=0, go=0, ball_rst=1, vel_x=vel_y=0, step_cnt=0, throws=0, busy=landed=timeout=0.
REQ-031 Reset mid-flight SHALL abandon the throw without incrementing throws; operation SHALL resume on the first clk after rst=1.

Configuration
REQ-032 Macro THROW_TIMEOUT_EN, when defined: in FLIGHT, a tick with step_cnt == MAX_STEPS and no landing SHALL move to ABORT.
REQ-033 Without THROW_TIMEOUT_EN: ABORT is unreachable, timeout is tied to 0, and FLIGHT ends only by landing or reset.

Verification
REQ-034 TICK_DIV=4, launch edge, vel_x_in=30, vel_y_in=80 -> ARM, vel_x=30, vel_y=80, go=1, ball_rst=0, first step on the next tick.
REQ-035 vel_y_in=900 -> vel_y=500; vel_x_in=500 -> vel_x=500.
REQ-036 Hold ball_y=400 for 5 ticks, then 445 -> 5 FLIGHT steps (6 including ARM), then LANDED, landed=1, throws=1, no step on the landing tick.
REQ-037 THROW_TIMEOUT_EN with MAX_STEPS=3 and ball_y held at 400 -> ABORT on the tick with step_cnt=3, timeout=1, throws=0; without the macro -> stepping continues.
REQ-038 rst=0 mid-FLIGHT, between clk edges -> outputs take their reset values immediately, throws=0; a launch edge in FLIGHT -> no effect.

Source files
------------

// File: rtl/throw_sequencer.sv
// Throw sequencer: paces a ball datapath with prescaled step ticks from launch to landing.
// Defining THROW_TIMEOUT_EN compiles in the MAX_STEPS flight abort (ABORT state).

module throw_sequencer #(
   parameter int TICK_DIV  = 833333,
   parameter int GROUND_Y  = 445,
   parameter int VEL_MAX   = 500,
   parameter int MAX_STEPS = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        launch,
   input  logic [9:0]  vel_x_in,
   input  logic [9:0]  vel_y_in,
   input  logic [8:0]  ball_y,
   output logic        step,
   output logic        go,
   output logic        ball_rst,
   output logic [9:0]  vel_x,
   output logic [9:0]  vel_y,
   output logic [10:0] step_cnt,
   output logic [7:0]  throws,
   output logic        busy,
   output logic        landed,
   output logic        timeout
);

   typedef enum logic [2:0] {IDLE, ARM, FLIGHT, LANDED, ABORT} state_t;

`ifdef THROW_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]   PRE_LAST   = PW'(TICK_DIV - 1);
   localparam logic [8:0]      GROUND     = 9'(GROUND_Y);
   localparam logic [9:0]      VEL_LIM    = 10'(VEL_MAX);
   localparam logic [10:0]     STEP_LIMIT = 11'(MAX_STEPS);

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          launch_q, launch_d;
   logic          step_q, step_d;
   logic [9:0]    vel_x_q, vel_x_d;
   logic [9:0]    vel_y_q, vel_y_d;
   logic [10:0]   step_cnt_q, step_cnt_d;
   logic [7:0]    throws_q, throws_d;

   logic tick, launch_edge, airborne, abort_hit;
   logic [10:0] step_cnt_inc;

   assign tick         = (presc_q == PRE_LAST);
   assign launch_edge  = launch & ~launch_q;
   assign airborne     = (ball_y < GROUND);
   assign abort_hit    = TIMEOUT_EN && (step_cnt_q == STEP_LIMIT);
   // step_cnt counts every step issued in the throw, including the one from ARM.
   assign step_cnt_inc = (step_cnt_q == 11'h7FF) ? step_cnt_q : step_cnt_q + 11'd1;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      presc_d    = tick ? '0 : presc_q + 1'b1;
      launch_d   = launch;
      state_d    = state_q;
      step_d     = 1'b0;
      vel_x_d    = vel_x_q;
      vel_y_d    = vel_y_q;
      step_cnt_d = step_cnt_q;
      throws_d   = throws_q;
      unique case (state_q)
         IDLE: if (launch_edge) begin
            state_d    = ARM;
            vel_x_d    = (vel_x_in > VEL_LIM) ? VEL_LIM : vel_x_in;
            vel_y_d    = (vel_y_in > VEL_LIM) ? VEL_LIM : vel_y_in;
            step_cnt_d = '0;
         end
         ARM: if (tick) begin
            state_d    = FLIGHT;
            step_d     = 1'b1;
            step_cnt_d = step_cnt_inc;
         end
         FLIGHT: if (tick) begin
            // Landing is tested first so it wins over the step limit on the same tick.
            if (!airborne) begin
               state_d  = LANDED;
               throws_d = (throws_q == 8'hFF) ? throws_q : throws_q + 8'd1;
            end else if (abort_hit) begin
               state_d = ABORT;
            end else begin
               step_d     = 1'b1;
               step_cnt_d = step_cnt_inc;
            end
         end
         LANDED, ABORT: if (launch_edge) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         presc_q    <= '0;
         launch_q   <= 1'b0;
         step_q     <= 1'b0;
         vel_x_q    <= '0;
         vel_y_q    <= '0;
         step_cnt_q <= '0;
         throws_q   <= '0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         launch_q   <= launch_d;
         step_q     <= step_d;
         vel_x_q    <= vel_x_d;
         vel_y_q    <= vel_y_d;
         step_cnt_q <= step_cnt_d;
         throws_q   <= throws_d;
      end
   end

   always_comb begin
      go       = (state_q == ARM) || (state_q == FLIGHT);
      busy     = go;
      ball_rst = (state_q == IDLE);
      landed   = (state_q == LANDED);
      timeout  = TIMEOUT_EN && (state_q == ABORT);
   end

   assign step     = step_q;
   assign vel_x    = vel_x_q;
   assign vel_y    = vel_y_q;
   assign step_cnt = step_cnt_q;
   assign throws   = throws_q;

endmodule
